// File: rtl/jk_excite_driver.sv
// jk_excite_driver
//   Command-driven stimulus/checker for a bank of WIDTH 74HC112-style JK flops.
//   Each accepted command drives J/K, the shared active-low set/clear pins and a
//   slow device clock. It then reads back the synchronized Q and reports
//   pass/fail.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//   cmd_op, cmd_target       00 STEP, 01 PRESET, 10 CLEAR, 11 TOGGLE; STEP target
//   j, k, sd_n, rd_n         registered device pins
//   jk_clk                   device clock, the device acts on its falling edge
//   q_in                     device Q, asynchronous to clk
//   rsp_valid/err/q          one-cycle response strobe, error flag, sampled Q
//   err_cnt                  saturating count of failed responses
module jk_excite_driver #(
    parameter int WIDTH     = 4,
    parameter int PULSE_CYC = 2,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_target,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             sd_n,
    output logic             rd_n,
    output logic             jk_clk,
    input  logic [WIDTH-1:0] q_in,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_q,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_HIGH, S_FORCE, S_SETTLE, S_RESP
    } state_t;

    localparam logic [1:0] OP_STEP   = 2'b00;
    localparam logic [1:0] OP_PRESET = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    // Phase counter must reach PULSE_CYC+1 (up to 16) in SETTLE.
    localparam int            CW     = 5;
    localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] S_LAST = CW'(PULSE_CYC + 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  exp_q, exp_d;
    logic [WIDTH-1:0]  j_q, j_d, k_q, k_d;
    logic              sdn_q, sdn_d, rdn_q, rdn_d, jkc_q, jkc_d;
    logic              rv_q, rv_d, rerr_q, rerr_d;
    logic [WIDTH-1:0]  rq_q, rq_d;
    logic [ERR_W-1:0]  ecnt_q, ecnt_d;
    logic [WIDTH-1:0]  qm_q, qs_q;
    logic              accept;
    logic              mismatch;

    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign mismatch  = (qs_q != exp_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        exp_d   = exp_q;
        j_d     = j_q;
        k_d     = k_q;
        rv_d    = 1'b0;
        rerr_d  = rerr_q;
        rq_d    = rq_q;
        ecnt_d  = ecnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = cmd_op;
                    cnt_d = '0;
                    // J/K are decided from the Q snapshot at accept so only
                    // the bits that must change are driven.
                    case (cmd_op)
                        OP_STEP: begin
                            exp_d   = cmd_target;
                            j_d     = cmd_target & ~qs_q;
                            k_d     = ~cmd_target & qs_q;
                            state_d = S_SETUP;
                        end
                        OP_TOGGLE: begin
                            exp_d   = ~qs_q;
                            j_d     = '1;
                            k_d     = '1;
                            state_d = S_SETUP;
                        end
                        OP_PRESET: begin
                            exp_d   = '1;
                            state_d = S_FORCE;
                        end
                        default: begin
                            exp_d   = '0;
                            state_d = S_FORCE;
                        end
                    endcase
                end
            end
            S_SETUP: begin
                if (cnt_q == P_LAST) begin
                    cnt_d   = '0;
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HIGH, S_FORCE: begin
                if (cnt_q == P_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SETTLE: begin
                // Two extra cycles cover the Q synchronizer latency.
                if (cnt_q == S_LAST) begin
                    cnt_d   = '0;
                    j_d     = '0;
                    k_d     = '0;
                    rv_d    = 1'b1;
                    rq_d    = qs_q;
                    rerr_d  = mismatch;
                    if (mismatch && (ecnt_q != '1))
                        ecnt_d = ecnt_q + ERR_W'(1);
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pin levels are decoded from the next state so they change on the same
    // edge as the state they belong to.
    always_comb begin
        jkc_d = (state_d == S_HIGH);
        sdn_d = !((state_d == S_FORCE) && (op_d == OP_PRESET));
        rdn_d = !((state_d == S_FORCE) && (op_d == OP_CLEAR));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_STEP;
            exp_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            sdn_q   <= 1'b1;
            rdn_q   <= 1'b1;
            jkc_q   <= 1'b0;
            rv_q    <= 1'b0;
            rerr_q  <= 1'b0;
            rq_q    <= '0;
            ecnt_q  <= '0;
            qm_q    <= '0;
            qs_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            exp_q   <= exp_d;
            j_q     <= j_d;
            k_q     <= k_d;
            sdn_q   <= sdn_d;
            rdn_q   <= rdn_d;
            jkc_q   <= jkc_d;
            rv_q    <= rv_d;
            rerr_q  <= rerr_d;
            rq_q    <= rq_d;
            ecnt_q  <= ecnt_d;
            qm_q    <= q_in;
            qs_q    <= qm_q;
        end
    end

    assign j         = j_q;
    assign k         = k_q;
    assign sd_n      = sdn_q;
    assign rd_n      = rdn_q;
    assign jk_clk    = jkc_q;
    assign rsp_valid = rv_q;
    assign rsp_err   = rerr_q;
    assign rsp_q     = rq_q;
    assign err_cnt   = ecnt_q;

endmodule

// File: tb/tb_jk_excite_driver.sv
// Bench for jk_excite_driver: a behavioural 74HC112 x4 device sits on the pins;
// every command is predicted from the op rules and checked cycle by cycle.
module tb_jk_excite_driver;

    localparam int W  = 4;
    localparam int P  = 2;
    localparam int EW = 8;
    localparam logic [1:0] STEP = 2'b00, PRESET = 2'b01, CLEAR = 2'b10, TOGGLE = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [W-1:0]  cmd_target = '0;
    logic [W-1:0]  j, k, q_in, rsp_q;
    logic          sd_n, rd_n, jk_clk, rsp_valid, rsp_err;
    logic [EW-1:0] err_cnt;

    int n_run  = 0;
    int n_fail = 0;

    jk_excite_driver #(.WIDTH(W), .PULSE_CYC(P), .ERR_W(EW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_target(cmd_target), .j(j), .k(k),
        .sd_n(sd_n), .rd_n(rd_n), .jk_clk(jk_clk), .q_in(q_in),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_q(rsp_q), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural device: async set/clear dominate, else JK on falling clock.
    logic [W-1:0] dev_q = '0;
    logic [W-1:0] stuck = '0;
    always @(negedge jk_clk or negedge sd_n or negedge rd_n) begin
        logic [W-1:0] nx;
        nx = dev_q;
        if (!sd_n)      nx = '1;
        else if (!rd_n) nx = '0;
        else begin
            for (int i = 0; i < W; i++)
                case ({j[i], k[i]})
                    2'b01:   nx[i] = 1'b0;
                    2'b10:   nx[i] = 1'b1;
                    2'b11:   nx[i] = ~dev_q[i];
                    default: nx[i] = dev_q[i];
                endcase
        end
        dev_q <= nx;
    end
    assign q_in = dev_q & ~stuck;

    // Reference state: predicted device contents, last response, error count.
    logic [W-1:0] tb_q    = '0;
    logic [W-1:0] last_rq = '0;
    int           exp_err = 0;

    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] tgt, input bit hold);
        logic [W-1:0] seen, jx, kx, expv, newq, rqx;
        logic [5+3*W+EW-1:0] got, want;
        bit steplike, errx;
        int r;
        seen = tb_q & ~stuck;
        jx = '0; kx = '0;
        case (op)
            STEP:    begin jx = tgt & ~seen; kx = ~tgt & seen; expv = tgt; newq = (tb_q | jx) & ~kx; end
            PRESET:  begin expv = '1; newq = '1; end
            CLEAR:   begin expv = '0; newq = '0; end
            default: begin jx = '1; kx = '1; expv = ~seen; newq = ~tb_q; end
        endcase
        steplike = (op == STEP) || (op == TOGGLE);
        r    = steplike ? 3*P+3 : 2*P+3;
        rqx  = newq & ~stuck;
        errx = (rqx != expv);

        @(negedge clk);
        n_run++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_idle op=%0d got=%b want=1", op, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_target = tgt;
        @(posedge clk); #1;
        if (hold) begin
            cmd_op = 2'($urandom); cmd_target = W'($urandom);
        end else cmd_valid = 1'b0;

        for (int n = 1; n <= r; n++) begin
            @(negedge clk);
            if (n == r && errx && exp_err < 255) exp_err++;
            want = {1'b0,
                    steplike && n >= P+1 && n <= 2*P,
                    !(op == PRESET && n <= P),
                    !(op == CLEAR && n <= P),
                    n == r,
                    (n < r) ? jx : {W{1'b0}},
                    (n < r) ? kx : {W{1'b0}},
                    (n < r) ? last_rq : rqx,
                    EW'(exp_err)};
            got = {cmd_ready, jk_clk, sd_n, rd_n, rsp_valid, j, k, rsp_q, err_cnt};
            n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL pins op=%0d tgt=%b cyc=%0d got=%h want=%h (rdy,clk,sd,rd,rv,j,k,q,cnt)",
                         op, tgt, n, got, want);
            end
            if (n == r) begin
                n_run++;
                if (rsp_err !== errx) begin
                    n_fail++;
                    $display("FAIL rsp_err op=%0d tgt=%b got=%b want=%b", op, tgt, rsp_err, errx);
                end
            end
        end
        last_rq = rqx;
        tb_q    = newq;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_run++;
        if ({cmd_ready, j, k, sd_n, rd_n, jk_clk, rsp_valid, rsp_err, rsp_q, err_cnt} !==
            {1'b0, {W{1'b0}}, {W{1'b0}}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}, {EW{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_values rdy=%b j=%b k=%b sd=%b rd=%b clk=%b rv=%b re=%b q=%b cnt=%0d",
                     cmd_ready, j, k, sd_n, rd_n, jk_clk, rsp_valid, rsp_err, rsp_q, err_cnt);
        end
        rst = 1'b0;
        last_rq = '0; exp_err = 0;
    endtask

    task automatic test_clear;
        run_cmd(CLEAR, '0, 1'b0);
    endtask

    task automatic test_step;
        run_cmd(STEP, 4'b1010, 1'b0);
        run_cmd(STEP, 4'b0110, 1'b0);
        run_cmd(STEP, 4'b0110, 1'b0);   // hold: clock edge with j=k=0
    endtask

    task automatic test_toggle_preset;
        run_cmd(TOGGLE, '0, 1'b0);
        run_cmd(PRESET, '0, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++)
            run_cmd(2'($urandom_range(0, 3)), W'($urandom), 1'b0);
    endtask

    task automatic test_err_saturate;
        stuck = 4'b0001;
        run_cmd(CLEAR, '0, 1'b0);
        for (int i = 0; i < 300; i++) run_cmd(STEP, 4'b0001, 1'b0);
        @(negedge clk);
        n_run++;
        if (err_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL err_saturate got=%0d want=255", err_cnt);
        end
        stuck = '0;
    endtask

    task automatic test_back_to_back;
        logic [1:0] ops [8];
        ops = '{PRESET, STEP, CLEAR, TOGGLE, STEP, TOGGLE, PRESET, CLEAR};
        for (int i = 0; i < 8; i++) run_cmd(ops[i], W'($urandom), 1'b1);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        // Reset while sd_n is low in FORCE.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = PRESET; cmd_target = '0;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        n_run++;
        if (sd_n !== 1'b0) begin n_fail++; $display("FAIL force_low got=%b want=0", sd_n); end
        rst = 1'b1;
        @(negedge clk);
        n_run++;
        if ({sd_n, rd_n, jk_clk, cmd_ready, rsp_valid, err_cnt} !== {4'b1100, 1'b0, {EW{1'b0}}}) begin
            n_fail++;
            $display("FAIL rst_in_force got sd=%b rd=%b clk=%b rdy=%b rv=%b cnt=%0d want 1,1,0,0,0,0",
                     sd_n, rd_n, jk_clk, cmd_ready, rsp_valid, err_cnt);
        end
        repeat (2) begin
            @(negedge clk);
            n_run++;
            if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_rsp got=%b want=0", rsp_valid); end
        end
        rst = 1'b0;
        last_rq = '0; exp_err = 0; tb_q = '1;

        // Reset while jk_clk is high.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = STEP; cmd_target = 4'b0101;
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (P+1) @(negedge clk);
        n_run++;
        if (jk_clk !== 1'b1) begin n_fail++; $display("FAIL high_phase got=%b want=1", jk_clk); end
        rst = 1'b1;
        @(negedge clk);
        n_run++;
        if ({jk_clk, cmd_ready, rsp_valid, sd_n, rd_n, j, k} !== {5'b00011, {W{1'b0}}, {W{1'b0}}}) begin
            n_fail++;
            $display("FAIL rst_in_high got clk=%b rdy=%b rv=%b sd=%b rd=%b j=%b k=%b want 0,0,0,1,1,0,0",
                     jk_clk, cmd_ready, rsp_valid, sd_n, rd_n, j, k);
        end
        @(negedge clk);
        rst = 1'b0;
        run_cmd(CLEAR, '0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL timeout");
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_clear();
        test_step();
        test_toggle_preset();
        test_random();
        test_err_saturate();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_excite_driver.md
Name: jk_excite_driver

Overview:
Command-driven controller that drives a bank of WIDTH 74HC112-style JK flip-flops from the other side of their pin interface. It generates J/K, active-low sd_n/rd_n and a slow JK clock with a falling-edge strobe. It reads back Q and reports pass/fail per command. It serves as the stimulus and checker for the lab's JK flip-flop and counter designs, and sits between a host or test sequencer and the device pins.

Parameters:
WIDTH, 4, number of JK flop channels driven and read back.
PULSE_CYC, 2, clk cycles per phase (setup, clock-high, force pulse); legal range 1..15.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  high only in IDLE; the command is accepted when cmd_valid && cmd_ready.
cmd_op  in  2  00 STEP, 01 PRESET, 10 CLEAR, 11 TOGGLE.
cmd_target  in  WIDTH  desired Q after STEP; ignored for other ops.
j  out  WIDTH  J pins, registered.
k  out  WIDTH  K pins, registered.
sd_n  out  1  common active-low asynchronous set, registered.
rd_n  out  1  common active-low asynchronous clear, registered.
jk_clk  out  1  device clock; the device samples on its falling edge.
q_in  in  WIDTH  device Q, asynchronous to clk.
rsp_valid  out  1  one-cycle response strobe.
rsp_err  out  1  valid with rsp_valid; 1 = synchronized Q != expected.
rsp_q  out  WIDTH  synchronized Q sampled at check; held until the next response.
err_cnt  out  ERR_W  count of failed responses; saturates at all-ones.

Behaviour:
- q_in passes through a 2-flop synchronizer (q_s). Its reset value is 0.
- Reset values: j=0, k=0, sd_n=1, rd_n=1, jk_clk=0, rsp_valid=0, rsp_err=0, rsp_q=0, err_cnt=0, state=IDLE. cmd_ready is 0 while rst is high and 1 on the first cycle after rst falls.
- States: IDLE, SETUP, HIGH, FORCE, SETTLE, RESP. A phase counter counts 0..PULSE_CYC-1 within SETUP, HIGH and FORCE, and 0..PULSE_CYC+1 within SETTLE.
- On accept, the block latches op and target, plus the snapshot qs0=q_s.
- Expected value:
  - STEP: target.
  - PRESET: all ones.
  - CLEAR: all zeros.
  - TOGGLE: ~qs0.
- IDLE to SETUP for STEP and TOGGLE; IDLE to FORCE for PRESET and CLEAR.
- SETUP (PULSE_CYC cycles) drives j and k:
  - STEP: j = target & ~qs0, k = ~target & qs0.
  - TOGGLE: j = k = all ones.
  - jk_clk stays 0 throughout.
- HIGH (PULSE_CYC cycles): jk_clk=1, with j and k held.
- Leaving HIGH drives jk_clk=0, which is the device's falling edge. The block then enters SETTLE with j and k still held.
- FORCE (PULSE_CYC cycles): PRESET drives sd_n=0; CLEAR drives rd_n=0. Never both. jk_clk stays 0. Both pins are released to 1 on entering SETTLE.
- SETTLE lasts PULSE_CYC+2 cycles to cover synchronizer latency. j and k return to 0 on leaving SETTLE.
- RESP (1 cycle):
  - rsp_valid=1, rsp_q=q_s, rsp_err=(q_s != expected).
  - err_cnt increments on error, saturating at all-ones.
  - The next state is IDLE.
- Latency, with accept at cycle 0 and P=PULSE_CYC:
  - STEP/TOGGLE: jk_clk rises at cycle P+1 and falls at 2P+1; rsp_valid at 3P+3; cmd_ready back at 3P+4.
  - PRESET/CLEAR: force pin low for cycles 1..P; rsp_valid at 2P+3; cmd_ready at 2P+4.
- cmd_valid asserted outside IDLE is ignored (not accepted) and causes no side effects.
- STEP with target == qs0 still issues a clock edge with j=k=0 (hold). The expected response is rsp_err=0.
- Reset mid-operation:
  - All outputs return to reset values on the next edge. The command is dropped with no response and err_cnt is cleared.
  - If reset hits during HIGH, the resulting jk_clk 1->0 is a real device edge; device state is then undefined until a PRESET or CLEAR.
- err_cnt never wraps.

Test Plan:
1. Reset, then CLEAR with WIDTH=4, P=2, against a behavioural 74HC112 x4 model -> rd_n low for cycles 1-2, rsp_valid at cycle 7, rsp_q=0000, rsp_err=0, err_cnt=0.
2. From 0000, STEP target=1010 -> j=1010, k=0000; jk_clk high for cycles 3-4 and falling at 5; rsp at cycle 9 with rsp_q=1010, rsp_err=0. Then STEP 0110 -> j=0100, k=1000, rsp_q=0110.
3. TOGGLE from 0110 -> j=k=1111, rsp_q=1001, rsp_err=0. PRESET -> sd_n low for 2 cycles, rsp_q=1111.
4. Model bit 0 stuck at 0, STEP 0001 -> rsp_err=1, rsp_q=0000, err_cnt=1. Force 300 failing commands -> err_cnt saturates at 255.
5. Hold cmd_valid high continuously with alternating ops -> exactly one accept per IDLE cycle, no accept in other states, sd_n and rd_n never low simultaneously.
6. Assert rst during FORCE (sd_n=0) and during HIGH -> next cycle sd_n=1, jk_clk=0, cmd_ready=0, no rsp_valid. After rst falls, a CLEAR restores rsp_q=0000.
